// File: rtl/pio_pkg.sv
// Shared register map and edge-mode encodings for the input PIO family.
package pio_pkg;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_RSV  = 2'd1;
  localparam logic [1:0] REG_MASK = 2'd2;
  localparam logic [1:0] REG_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/pio_sync.sv
// Multi-bit flop-chain synchronizer; q follows d after SYNC_STAGES clocks.
module pio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] chain [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/avalon_pio_in_irq.sv
// Avalon-MM input PIO with sticky per-bit edge capture and a maskable level irq.
// Read latency 1; writes always accepted (no waitrequest).
module avalon_pio_in_irq
  import pio_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int EDGE_TYPE    = 0,
  parameter int SYNC_STAGES  = 2,
  parameter int BIT_CLEARING = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_next;
  logic             wr;
  logic             unused_wdata;

  pio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (sync_q)
  );

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: edge_det = ~sync_q & prev;
      EDGE_ANY:  edge_det = sync_q ^ prev;
      default:   edge_det = sync_q & ~prev;
    endcase
  end

  always_comb begin
    clr = '0;
    if (wr && address == REG_EDGE) begin
      clr = (BIT_CLEARING != 0) ? writedata[WIDTH-1:0] : '1;
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      REG_DATA: rd_next[WIDTH-1:0] = sync_q;
      REG_MASK: rd_next[WIDTH-1:0] = irq_mask;
      REG_EDGE: rd_next[WIDTH-1:0] = edge_capture;
      default:  rd_next = '0;
    endcase
  end

  // A new edge is OR-ed in after the clear so it is never lost to a coincident write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev         <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      readdata     <= '0;
    end else begin
      prev         <= sync_q;
      edge_capture <= (edge_capture & ~clr) | edge_det;
      readdata     <= rd_next;
      if (wr && address == REG_MASK) irq_mask <= writedata[WIDTH-1:0];
    end
  end

  assign irq = |(edge_capture & irq_mask);
endmodule

// File: tb/tb_avalon_pio_in_irq.sv
// Drives four differently-parameterised PIOs from one bus and compares each against a sample-history model.
module tb_avalon_pio_in_irq;
  localparam int N = 4;
  localparam int ET [N] = '{0, 1, 2, 2};
  localparam int BC [N] = '{1, 1, 0, 1};
  localparam int WD [N] = '{8, 8, 8, 5};
  localparam int SS [N] = '{2, 2, 2, 3};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [7:0]  in_port = 8'd0;
  logic [31:0] rd_dut [N];
  logic        irq_dut [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avalon_pio_in_irq #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2), .BIT_CLEARING(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_dut[0]), .irq(irq_dut[0]));
  avalon_pio_in_irq #(.WIDTH(8), .EDGE_TYPE(1), .SYNC_STAGES(2), .BIT_CLEARING(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_dut[1]), .irq(irq_dut[1]));
  avalon_pio_in_irq #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2), .BIT_CLEARING(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_dut[2]), .irq(irq_dut[2]));
  avalon_pio_in_irq #(.WIDTH(5), .EDGE_TYPE(2), .SYNC_STAGES(3), .BIT_CLEARING(1)) dut3 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port[4:0]), .readdata(rd_dut[3]), .irq(irq_dut[3]));

  // Model: m_h[k][j] is the in_port sample taken j+1 edges ago, so the synchronized
  // value is the sample SS edges old and the previous one is SS+1 edges old.
  logic [31:0] m_h [N][5];
  logic [31:0] m_mask [N];
  logic [31:0] m_cap [N];
  logic [31:0] m_rd [N];
  logic [31:0] m_sq, m_pv, m_e;

  function automatic logic [31:0] wm(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) begin
        for (int j = 0; j < 5; j++) m_h[k][j] = 32'd0;
        m_mask[k] = 32'd0;
        m_cap[k]  = 32'd0;
        m_rd[k]   = 32'd0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        m_sq = m_h[k][SS[k]-1];
        m_pv = m_h[k][SS[k]];
        case (ET[k])
          0:       m_e = m_sq & ~m_pv;
          1:       m_e = ~m_sq & m_pv;
          default: m_e = m_sq ^ m_pv;
        endcase
        case (address)
          2'd0:    m_rd[k] = m_sq;
          2'd2:    m_rd[k] = m_mask[k];
          2'd3:    m_rd[k] = m_cap[k];
          default: m_rd[k] = 32'd0;
        endcase
        if (chipselect && !write_n && address == 2'd2) m_mask[k] = writedata & wm(WD[k]);
        if (chipselect && !write_n && address == 2'd3)
          m_cap[k] = m_cap[k] & ~((BC[k] != 0) ? writedata : 32'hFFFF_FFFF);
        m_cap[k] = (m_cap[k] | m_e) & wm(WD[k]);
        for (int j = 4; j > 0; j--) m_h[k][j] = m_h[k][j-1];
        m_h[k][0] = {24'd0, in_port} & wm(WD[k]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      check($sformatf("rd%0d", k), rd_dut[k], m_rd[k]);
      check($sformatf("irq%0d", k), {31'd0, irq_dut[k]}, {31'd0, |(m_cap[k] & m_mask[k])});
    end
  end

  // Hand-computed value checked against both the DUT and the model.
  task automatic pin(input int k, input string name, input logic [31:0] exp);
    check(name, rd_dut[k], exp);
    check({name, "_model"}, m_rd[k], exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    in_port = 8'hFF;
    idle(3);
    check("rst_rd", rd_dut[0], 32'd0);
    check("rst_irq", {31'd0, irq_dut[0]}, 32'd0);
    reset_n = 1'b1;
    idle(4);
    address = 2'd0;
    idle(1);
    pin(0, "data_ff", 32'h0000_00FF);
    pin(3, "data_w5", 32'h0000_001F);
    wr(2'd3, 32'hFF);
    in_port = 8'h00;
    idle(6);
    wr(2'd3, 32'hFF);

    in_port = 8'h05;
    idle(4);
    pin(0, "rise_05", 32'h05);
    check("irq_masked", {31'd0, irq_dut[0]}, 32'd0);

    wr(2'd2, 32'h04);
    check("irq_unmask", {31'd0, irq_dut[0]}, 32'd1);
    wr(2'd3, 32'h04);
    check("irq_cleared", {31'd0, irq_dut[0]}, 32'd0);
    idle(1);
    pin(0, "w1c_01", 32'h01);

    in_port = 8'h04;
    idle(5);
    in_port = 8'h05;
    idle(2);
    wr(2'd3, 32'h01);
    idle(1);
    pin(0, "set_wins", 32'h01);

    in_port = 8'hFF;
    idle(6);
    wr(2'd3, 32'hFF);
    in_port = 8'hF0;
    idle(6);
    pin(1, "fall_0f", 32'h0F);

    wr(2'd3, 32'hFF);
    in_port = 8'h70;
    idle(3);
    in_port = 8'hF0;
    idle(6);
    pin(2, "any_80", 32'h80);
    wr(2'd3, 32'h00);
    idle(1);
    pin(2, "bc0_clear", 32'h00);

    in_port = 8'h00;
    idle(5);
    wr(2'd2, 32'hFF);
    wr(2'd3, 32'hFF);
    in_port = 8'h3C;
    idle(6);
    pin(0, "edge_3c", 32'h3C);
    check("irq_3c", {31'd0, irq_dut[0]}, 32'd1);
    #1 reset_n = 1'b0;
    in_port = 8'h00;
    #1 check("arst_irq", {31'd0, irq_dut[0]}, 32'd0);
    check("arst_rd", rd_dut[0], 32'd0);
    #1 reset_n = 1'b1;
    idle(1);
    pin(0, "edge_rst", 32'd0);
    address = 2'd2;
    idle(1);
    pin(0, "mask_rst", 32'd0);

    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
    end
    chipselect = 1'b0;
    write_n = 1'b1;
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
